// File: rtl/mem_wb_skid_if.sv
// MEM->WB handshake bundle: MEM-side entry inputs with in_ready, and the
// writeback-side head entry with out_ready.
interface mem_wb_skid_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5,
  parameter int MR_W = 2
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_in;
  logic [XLEN-1:0] pc_add4;
  logic [XLEN-1:0] dataR_in;
  logic [RA_W-1:0] rd;
  logic            RegW;
  logic [MR_W-1:0] MemReg;

  logic            out_valid;
  logic            out_ready;
  logic            RegW_out;
  logic [MR_W-1:0] MemReg_out;
  logic [RA_W-1:0] rd_out;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] pc_add4_out;
  logic [XLEN-1:0] dataR_out;

  modport master (
    output in_valid, alu_in, pc_add4, dataR_in, rd, RegW, MemReg, out_ready,
    input  in_ready, out_valid, RegW_out, MemReg_out, rd_out,
           alu_out, pc_add4_out, dataR_out
  );

  modport slave (
    input  in_valid, alu_in, pc_add4, dataR_in, rd, RegW, MemReg, out_ready,
    output in_ready, out_valid, RegW_out, MemReg_out, rd_out,
           alu_out, pc_add4_out, dataR_out
  );
endinterface

// File: rtl/mem_wb_skid.sv
// MEM->WB pipeline stage with a two-entry skid buffer; in_ready depends only on
// state and flush, and all outputs come from the main register.
module mem_wb_skid #(
  parameter int XLEN       = 32,
  parameter int RA_W       = 5,
  parameter int MR_W       = 2,
  parameter int ZERO_GUARD = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  mem_wb_skid_if.slave        bus,
  output logic [1:0]          occupancy
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic GUARD = (ZERO_GUARD != 0);

  typedef struct packed {
    logic            regw;
    logic [MR_W-1:0] memreg;
    logic [RA_W-1:0] rd;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } entry_t;

  logic [1:0] state_q;
  logic [1:0] state_d;
  entry_t     in_e;
  entry_t     main_q;
  entry_t     skid_q;
  logic       in_fire;
  logic       out_fire;
  logic       out_valid;
  logic       load_main_in;
  logic       load_main_skid;
  logic       load_skid;

  assign in_e = '{regw:   bus.RegW,
                  memreg: bus.MemReg,
                  rd:     bus.rd,
                  alu:    bus.alu_in,
                  pc:     bus.pc_add4,
                  data:   bus.dataR_in};

  assign bus.in_ready = (state_q != ST_FULL) && !flush;
  assign out_valid    = (state_q != ST_EMPTY);
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d      = ST_BUSY;
            load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (in_fire && !out_fire) begin
            state_d   = ST_FULL;
            load_skid = 1'b1;
          end else if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q    <= '0;
      main_q.rd <= '1;
      skid_q    <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= in_e;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_e;
      end
    end
  end

  assign bus.out_valid   = out_valid;
  assign bus.RegW_out    = out_valid && main_q.regw && !(GUARD && (main_q.rd == '0));
  assign bus.MemReg_out  = main_q.memreg;
  assign bus.rd_out      = main_q.rd;
  assign bus.alu_out     = main_q.alu;
  assign bus.pc_add4_out = main_q.pc;
  assign bus.dataR_out   = main_q.data;
  assign occupancy       = state_q;

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed bench for mem_wb_skid: reset values, streaming, backpressure,
// flush, x0 write guard (both guard settings) and asynchronous reset.
module tb_mem_wb_skid;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] occ0;
  logic [1:0] occ1;
  int         vectors;
  int         miscompares;

  mem_wb_skid_if #(.XLEN(32), .RA_W(5), .MR_W(2)) bus0 ();
  mem_wb_skid_if #(.XLEN(32), .RA_W(5), .MR_W(2)) bus1 ();

  mem_wb_skid #(.XLEN(32), .RA_W(5), .MR_W(2), .ZERO_GUARD(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0), .occupancy(occ0)
  );

  mem_wb_skid #(.XLEN(32), .RA_W(5), .MR_W(2), .ZERO_GUARD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1), .occupancy(occ1)
  );

  // The unguarded instance sees identical stimulus.
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.alu_in    = bus0.alu_in;
  assign bus1.pc_add4   = bus0.pc_add4;
  assign bus1.dataR_in  = bus0.dataR_in;
  assign bus1.rd        = bus0.rd;
  assign bus1.RegW      = bus0.RegW;
  assign bus1.MemReg    = bus0.MemReg;
  assign bus1.out_ready = bus0.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [31:0] a, input logic [4:0] r,
                      input logic w, input logic [1:0] m);
    bus0.in_valid = v;
    bus0.alu_in   = a;
    bus0.pc_add4  = a + 32'h1000_0000;
    bus0.dataR_in = a ^ 32'hFFFF_0000;
    bus0.rd       = r;
    bus0.RegW     = w;
    bus0.MemReg   = m;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] a, input logic [4:0] r,
                          input logic [1:0] m);
    chk({tag, "_valid"}, 32'(bus0.out_valid), 1);
    chk({tag, "_alu"},   bus0.alu_out, a);
    chk({tag, "_pc"},    bus0.pc_add4_out, a + 32'h1000_0000);
    chk({tag, "_data"},  bus0.dataR_out, a ^ 32'hFFFF_0000);
    chk({tag, "_rd"},    32'(bus0.rd_out), 32'(r));
    chk({tag, "_mr"},    32'(bus0.MemReg_out), 32'(m));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b1;
    flush       = 1'b0;
    bus0.out_ready = 1'b0;
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);

    // Reset held with random inputs
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
           2'($urandom));
      bus0.out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_valid", 32'(bus0.out_valid), 0);
    chk("rst_regw",  32'(bus0.RegW_out), 0);
    chk("rst_rd",    32'(bus0.rd_out), 32'h1F);
    chk("rst_alu",   bus0.alu_out, 0);
    chk("rst_pc",    bus0.pc_add4_out, 0);
    chk("rst_data",  bus0.dataR_out, 0);
    chk("rst_mr",    32'(bus0.MemReg_out), 0);
    chk("rst_occ",   32'(occ0), 0);
    chk("rst_inrdy", 32'(bus0.in_ready), 1);
    flush = 1'b1;
    #1 chk("rst_inrdy_flush", 32'(bus0.in_ready), 0);
    flush = 1'b0;
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    #1 rst_n = 1'b1;
    tick();

    // Back-to-back stream
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 32'h100 + 32'(i), 5'(i + 1), 1'b1, 2'(i));
      chk("stream_inrdy", 32'(bus0.in_ready), 1);
      tick();
      chk_head("stream", 32'h100 + 32'(i), 5'(i + 1), 2'(i));
      chk("stream_occ", 32'(occ0), 1);
      chk("stream_regw", 32'(bus0.RegW_out), 1);
    end
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    tick();
    chk("drain_valid", 32'(bus0.out_valid), 0);
    chk("drain_occ",   32'(occ0), 0);
    chk("drain_regw",  32'(bus0.RegW_out), 0);
    chk("drain_stale", bus0.alu_out, 32'h107);

    // Backpressure: A on outputs, B into skid, C held off
    send(1'b1, 32'h200, 5'd3, 1'b1, 2'd1);
    tick();
    chk_head("bp_a", 32'h200, 5'd3, 2'd1);
    bus0.out_ready = 1'b0;
    send(1'b1, 32'h201, 5'd4, 1'b1, 2'd2);
    tick();
    chk("bp_occ2",  32'(occ0), 2);
    chk("bp_inrdy", 32'(bus0.in_ready), 0);
    chk_head("bp_hold1", 32'h200, 5'd3, 2'd1);
    send(1'b1, 32'h202, 5'd5, 1'b1, 2'd3);
    tick();
    chk("bp_occ2b", 32'(occ0), 2);
    chk_head("bp_hold2", 32'h200, 5'd3, 2'd1);
    bus0.out_ready = 1'b1;
    tick();
    chk_head("bp_b", 32'h201, 5'd4, 2'd2);
    chk("bp_occ1", 32'(occ0), 1);
    tick();
    chk_head("bp_c", 32'h202, 5'd5, 2'd3);
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    tick();
    chk("bp_empty", 32'(bus0.out_valid), 0);

    // Flush while FULL with D offered
    bus0.out_ready = 1'b0;
    send(1'b1, 32'h300, 5'd6, 1'b1, 2'd0);
    tick();
    send(1'b1, 32'h301, 5'd7, 1'b1, 2'd0);
    tick();
    chk("fl_occ2", 32'(occ0), 2);
    send(1'b1, 32'h3DD, 5'd8, 1'b1, 2'd0);
    flush = 1'b1;
    #1 chk("fl_inrdy", 32'(bus0.in_ready), 0);
    tick();
    chk("fl_valid", 32'(bus0.out_valid), 0);
    chk("fl_occ",   32'(occ0), 0);
    chk("fl_regw",  32'(bus0.RegW_out), 0);
    flush = 1'b0;
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    bus0.out_ready = 1'b1;
    tick();
    chk("fl_noD_valid", 32'(bus0.out_valid), 0);
    chk("fl_noD_alu_ne", 32'(bus0.alu_out == 32'h3DD), 0);

    // x0 guard on both instances
    send(1'b1, 32'h400, 5'd0, 1'b1, 2'd0);
    tick();
    chk("x0_rd",     32'(bus0.rd_out), 0);
    chk("x0_g1",     32'(bus0.RegW_out), 0);
    chk("x0_g0",     32'(bus1.RegW_out), 1);
    send(1'b1, 32'h401, 5'd7, 1'b1, 2'd0);
    tick();
    chk("x7_g1",     32'(bus0.RegW_out), 1);
    chk("x7_g0",     32'(bus1.RegW_out), 1);
    send(1'b1, 32'h402, 5'd5, 1'b0, 2'd0);
    tick();
    chk("nowr_g1",   32'(bus0.RegW_out), 0);
    chk("nowr_g0",   32'(bus1.RegW_out), 0);
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    tick();

    // Asynchronous reset while FULL
    bus0.out_ready = 1'b0;
    send(1'b1, 32'h500, 5'd9, 1'b1, 2'd2);
    tick();
    send(1'b1, 32'h501, 5'd10, 1'b1, 2'd2);
    tick();
    chk("ar_occ2", 32'(occ0), 2);
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus0.out_valid), 0);
    chk("ar_occ",   32'(occ0), 0);
    chk("ar_rd",    32'(bus0.rd_out), 32'h1F);
    chk("ar_alu",   bus0.alu_out, 0);
    chk("ar_regw",  32'(bus0.RegW_out), 0);
    #1 rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    send(1'b1, 32'h600, 5'd11, 1'b1, 2'd1);
    tick();
    chk_head("ar_after", 32'h600, 5'd11, 2'd1);
    chk("ar_after_regw", 32'(bus0.RegW_out), 1);
    send(1'b0, 32'h0, 5'd0, 1'b0, 2'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
